// File: rtl/scarv_soc_pkg.sv
// rtl/scarv_soc_pkg.sv - shared BRAM arbiter state encodings and requester count
package scarv_soc_pkg;

    localparam int unsigned SCARV_SOC_BRAM_NREQ = 2;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_RESP = 2'd1,
        ARB_HOLD = 2'd2
    } arb_state_e;

endpackage

// File: rtl/scarv_soc_rr_arbiter.sv
// rtl/scarv_soc_rr_arbiter.sv - two-way winner select; round-robin with SCARV_SOC_BRAM_ARB_RR_EN, fixed r0 priority otherwise
module scarv_soc_rr_arbiter
    import scarv_soc_pkg::*;
(
    input  logic [SCARV_SOC_BRAM_NREQ-1:0] req_i,
    input  logic                           en_i,
    input  logic                           last_i,
    output logic [SCARV_SOC_BRAM_NREQ-1:0] gnt_o
);

`ifdef SCARV_SOC_BRAM_ARB_RR_EN
    // On contention the requester not granted last wins.
    always_comb begin
        gnt_o = '0;
        if (en_i) begin
            if (req_i[0] && req_i[1]) begin
                gnt_o = last_i ? 2'b01 : 2'b10;
            end else begin
                gnt_o = req_i;
            end
        end
    end
`else
    logic unused_last;
    assign unused_last = last_i;

    always_comb begin
        gnt_o = '0;
        if (en_i) begin
            gnt_o = req_i[0] ? 2'b01 : req_i;
        end
    end
`endif

endmodule

// File: rtl/scarv_soc_bram_arbiter.sv
// rtl/scarv_soc_bram_arbiter.sv - two requesters share BRAM port A; SCARV_SOC_BRAM_ARB_RR_EN selects round-robin
module scarv_soc_bram_arbiter
    import scarv_soc_pkg::*;
#(
    parameter int DEPTH = 1024,
    localparam int LW   = $clog2(DEPTH)
) (
    input  logic          clka,
    input  logic          rsta,

    input  logic          r0_req,
    output logic          r0_gnt,
    input  logic [3:0]    r0_wen,
    input  logic [LW-1:0] r0_addr,
    input  logic [31:0]   r0_wdata,
    output logic          r0_rsp,
    input  logic          r0_rsp_ready,
    output logic [31:0]   r0_rdata,

    input  logic          r1_req,
    output logic          r1_gnt,
    input  logic [3:0]    r1_wen,
    input  logic [LW-1:0] r1_addr,
    input  logic [31:0]   r1_wdata,
    output logic          r1_rsp,
    input  logic          r1_rsp_ready,
    output logic [31:0]   r1_rdata,

    output logic          ena,
    output logic [3:0]    wea,
    output logic [LW-1:0] addra,
    output logic [31:0]   dina,
    input  logic [31:0]   douta
);

    arb_state_e  state_q;
    logic        owner_q;
    logic [31:0] hold_q;
    logic        last_w;

    logic [SCARV_SOC_BRAM_NREQ-1:0] req_w;
    logic [SCARV_SOC_BRAM_NREQ-1:0] gnt_w;
    logic        any_gnt;
    logic        winner;
    logic        owner_ready;
    logic        rsp_active;
    logic        grant_en;
    logic [31:0] rsp_data;

    assign req_w       = {r1_req, r0_req};
    assign owner_ready = owner_q ? r1_rsp_ready : r0_rsp_ready;
    assign rsp_active  = (state_q == ARB_RESP) || (state_q == ARB_HOLD);
    // An unaccepted response stalls the port so the BRAM output is not overwritten.
    assign grant_en    = !rsta && !(rsp_active && !owner_ready);
    assign any_gnt     = |gnt_w;
    assign winner      = gnt_w[1];

    scarv_soc_rr_arbiter u_rr_arbiter (
        .req_i  (req_w),
        .en_i   (grant_en),
        .last_i (last_w),
        .gnt_o  (gnt_w)
    );

    assign r0_gnt = gnt_w[0];
    assign r1_gnt = gnt_w[1];

    always_comb begin
        ena   = any_gnt;
        wea   = '0;
        addra = '0;
        dina  = '0;
        if (any_gnt) begin
            wea   = winner ? r1_wen   : r0_wen;
            addra = winner ? r1_addr  : r0_addr;
            dina  = winner ? r1_wdata : r0_wdata;
        end
    end

    assign rsp_data = (state_q == ARB_HOLD) ? hold_q : douta;
    assign r0_rsp   = rsp_active && !owner_q;
    assign r1_rsp   = rsp_active &&  owner_q;
    assign r0_rdata = r0_rsp ? rsp_data : '0;
    assign r1_rdata = r1_rsp ? rsp_data : '0;

`ifdef SCARV_SOC_BRAM_ARB_RR_EN
    logic last_q;
    assign last_w = last_q;

    always_ff @(posedge clka) begin
        if (rsta) begin
            last_q <= 1'b1;
        end else if (any_gnt) begin
            last_q <= winner;
        end
    end
`else
    assign last_w = 1'b1;
`endif

    always_ff @(posedge clka) begin
        if (rsta) begin
            state_q <= ARB_IDLE;
            owner_q <= 1'b0;
            hold_q  <= '0;
        end else if (any_gnt) begin
            state_q <= ARB_RESP;
            owner_q <= winner;
        end else begin
            case (state_q)
                ARB_RESP: begin
                    if (!owner_ready) begin
                        state_q <= ARB_HOLD;
                        hold_q  <= douta;
                    end else begin
                        state_q <= ARB_IDLE;
                    end
                end
                ARB_HOLD: begin
                    if (owner_ready) begin
                        state_q <= ARB_IDLE;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scarv_soc_bram_arbiter.sv
// tb/tb_scarv_soc_bram_arbiter.sv - directed scoreboard bench for scarv_soc_bram_arbiter
module tb_scarv_soc_bram_arbiter;

    localparam int DEPTH = 1024;
    localparam int LW    = 10;

    logic          clka = 1'b0;
    logic          rsta;
    logic          r0_req, r1_req, r0_gnt, r1_gnt;
    logic [3:0]    r0_wen, r1_wen;
    logic [LW-1:0] r0_addr, r1_addr;
    logic [31:0]   r0_wdata, r1_wdata, r0_rdata, r1_rdata;
    logic          r0_rsp, r1_rsp, r0_rsp_ready, r1_rsp_ready;
    logic          ena;
    logic [3:0]    wea;
    logic [LW-1:0] addra;
    logic [31:0]   dina;
    logic [31:0]   douta;

    always #5 clka = ~clka;

    scarv_soc_bram_arbiter #(.DEPTH(DEPTH)) dut (
        .clka(clka), .rsta(rsta),
        .r0_req(r0_req), .r0_gnt(r0_gnt), .r0_wen(r0_wen), .r0_addr(r0_addr),
        .r0_wdata(r0_wdata), .r0_rsp(r0_rsp), .r0_rsp_ready(r0_rsp_ready), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_gnt(r1_gnt), .r1_wen(r1_wen), .r1_addr(r1_addr),
        .r1_wdata(r1_wdata), .r1_rsp(r1_rsp), .r1_rsp_ready(r1_rsp_ready), .r1_rdata(r1_rdata),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta)
    );

    // BRAM port A: read-first, output valid the cycle after ena, garbage otherwise
    logic [31:0] mem [DEPTH/4];
    always @(posedge clka) begin
        if (ena) begin
            douta <= mem[addra[LW-1:2]];
            for (int b = 0; b < 4; b++) begin
                if (wea[b]) mem[addra[LW-1:2]][b*8 +: 8] <= dina[b*8 +: 8];
            end
        end else begin
            douta <= $urandom;
        end
    end

    typedef struct {
        int          port;
        bit          is_read;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ref_mem [DEPTH/4];
    int          checks = 0;
    int          errors = 0;
    int          exp_last = 1;
    logic [31:0] last_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int p, input logic req, input logic [3:0] wen,
                           input logic [LW-1:0] addr, input logic [31:0] wd);
        if (p == 0) begin
            r0_req = req; r0_wen = wen; r0_addr = addr; r0_wdata = wd;
        end else begin
            r1_req = req; r1_wen = wen; r1_addr = addr; r1_wdata = wd;
        end
    endtask

    task automatic push_exp(input int p, input logic [3:0] wen, input logic [LW-1:0] addr,
                            input logic [31:0] wd);
        exp_t e;
        e.port    = p;
        e.is_read = (wen == 4'h0);
        e.data    = ref_mem[addr[LW-1:2]];
        for (int b = 0; b < 4; b++) begin
            if (wen[b]) ref_mem[addr[LW-1:2]][b*8 +: 8] = wd[b*8 +: 8];
        end
        sb.push_back(e);
        exp_last = p;
    endtask

    task automatic pop_chk(input string tag);
        exp_t e;
        chk({tag, "_sb_pending"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_rsp"}, (e.port == 1) ? r1_rsp : r0_rsp, 32'd1);
            last_rdata = (e.port == 1) ? r1_rdata : r0_rdata;
            if (e.is_read) chk({tag, "_rdata"}, last_rdata, e.data);
        end
    endtask

    // Grant in the request cycle, response the following cycle.
    task automatic access(input string tag, input int p, input logic [3:0] wen,
                          input logic [LW-1:0] addr, input logic [31:0] wd);
        logic g;
        set_req(p, 1'b1, wen, addr, wd);
        #1;
        g = (p == 1) ? r1_gnt : r0_gnt;
        chk({tag, "_gnt"}, g, 32'd1);
        chk({tag, "_ena"}, ena, 32'd1);
        chk({tag, "_addra"}, addra, addr);
        chk({tag, "_wea"}, wea, wen);
        if (g) push_exp(p, wen, addr, wd);
        @(posedge clka); #1;
        set_req(p, 1'b0, 4'h0, '0, '0);
        #1;
        if (g) pop_chk(tag);
    endtask

    initial begin
        int exp_w;
        for (int i = 0; i < DEPTH/4; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
        rsta = 1'b1;
        set_req(0, 1'b1, 4'h0, '0, '0);
        set_req(1, 1'b0, 4'h0, '0, '0);
        r0_rsp_ready = 1'b1;
        r1_rsp_ready = 1'b1;

        // Reset blocks grants and BRAM strobes
        @(posedge clka); #1;
        chk("rst_r0_gnt", r0_gnt, 32'd0);
        chk("rst_ena", ena, 32'd0);
        chk("rst_wea", wea, 32'd0);
        @(posedge clka); #1;
        rsta = 1'b0;
        set_req(0, 1'b0, 4'h0, '0, '0);
        #1;
        chk("post_rst_r0_rsp", r0_rsp, 32'd0);
        chk("post_rst_r1_rsp", r1_rsp, 32'd0);
        chk("post_rst_r0_rdata", r0_rdata, 32'd0);
        chk("post_rst_r1_rdata", r1_rdata, 32'd0);
        chk("post_rst_addra", addra, 32'd0);
        chk("post_rst_dina", dina, 32'd0);

        // Single write then read
        access("wr10", 0, 4'hF, 10'h010, 32'hDEADBEEF);
        access("rd10", 0, 4'h0, 10'h010, 32'h0);
        chk("rd10_value", last_rdata, 32'hDEADBEEF);

        // Byte strobe merge
        access("wr20", 0, 4'hF, 10'h020, 32'h11223344);
        access("wr20b", 0, 4'b0001, 10'h020, 32'h000000AA);
        access("rd20", 0, 4'h0, 10'h020, 32'h0);
        chk("rd20_value", last_rdata, 32'h112233AA);

        access("wr40", 1, 4'hF, 10'h040, 32'hCAFEF00D);
        @(posedge clka); #1;

        // Contention for six cycles
        set_req(0, 1'b1, 4'h0, 10'h010, '0);
        set_req(1, 1'b1, 4'h0, 10'h040, '0);
        for (int i = 0; i < 6; i++) begin
            #1;
            if (sb.size() > 0) pop_chk("cont");
`ifdef SCARV_SOC_BRAM_ARB_RR_EN
            exp_w = (exp_last == 0) ? 1 : 0;
`else
            exp_w = 0;
`endif
            chk("cont_r0_gnt", r0_gnt, 32'(exp_w == 0));
            chk("cont_r1_gnt", r1_gnt, 32'(exp_w == 1));
            if (exp_w == 0) push_exp(0, 4'h0, 10'h010, '0);
            else            push_exp(1, 4'h0, 10'h040, '0);
            @(posedge clka); #1;
        end
        set_req(0, 1'b0, 4'h0, '0, '0);
        set_req(1, 1'b0, 4'h0, '0, '0);
        #1;
        pop_chk("cont_last");
        @(posedge clka); #1;

        // Backpressure: r1 holds its response for three cycles
        r1_rsp_ready = 1'b0;
        set_req(1, 1'b1, 4'h0, 10'h040, '0);
        #1;
        chk("bp_r1_gnt", r1_gnt, 32'd1);
        if (r1_gnt) push_exp(1, 4'h0, 10'h040, '0);
        @(posedge clka); #1;
        set_req(1, 1'b0, 4'h0, '0, '0);
        set_req(0, 1'b1, 4'h0, 10'h020, '0);
        #1;
        chk("bp_resp_rsp", r1_rsp, 32'd1);
        chk("bp_resp_rdata", r1_rdata, 32'hCAFEF00D);
        chk("bp_resp_r0_gnt", r0_gnt, 32'd0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clka); #2;
            chk("bp_hold_state", 32'(dut.state_q), 32'd2);
            chk("bp_hold_rsp", r1_rsp, 32'd1);
            chk("bp_hold_rdata", r1_rdata, 32'hCAFEF00D);
            chk("bp_hold_r0_gnt", r0_gnt, 32'd0);
            chk("bp_hold_ena", ena, 32'd0);
        end
        r1_rsp_ready = 1'b1;
        #1;
        chk("bp_release_r0_gnt", r0_gnt, 32'd1);
        pop_chk("bp_release");
        if (r0_gnt) push_exp(0, 4'h0, 10'h020, '0);
        @(posedge clka); #1;
        set_req(0, 1'b0, 4'h0, '0, '0);
        #1;
        pop_chk("bp_r0");
        chk("bp_r0_value", last_rdata, 32'h112233AA);
        @(posedge clka); #1;

        // Reset during RESP discards the response
        set_req(0, 1'b1, 4'h0, 10'h010, '0);
        #1;
        chk("rm_gnt", r0_gnt, 32'd1);
        @(posedge clka); #1;
        rsta = 1'b1;
        set_req(1, 1'b1, 4'h0, 10'h040, '0);
        #1;
        chk("rm_ena", ena, 32'd0);
        chk("rm_r0_gnt", r0_gnt, 32'd0);
        chk("rm_r1_gnt", r1_gnt, 32'd0);
        @(posedge clka); #1;
        rsta = 1'b0;
        exp_last = 1;
        #1;
        chk("rm_r0_rsp", r0_rsp, 32'd0);
        chk("rm_r0_rdata", r0_rdata, 32'd0);
        chk("rm_cont_r0_gnt", r0_gnt, 32'd1);
        chk("rm_cont_r1_gnt", r1_gnt, 32'd0);
        if (r0_gnt) push_exp(0, 4'h0, 10'h010, '0);
        @(posedge clka); #1;
        set_req(0, 1'b0, 4'h0, '0, '0);
        set_req(1, 1'b0, 4'h0, '0, '0);
        #1;
        pop_chk("rm_after");
        chk("rm_after_value", last_rdata, 32'hDEADBEEF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scarv_soc_bram_arbiter.md
SCARV_SOC_BRAM_ARBITER -- requirements
Module: scarv_soc_bram_arbiter

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
  - DEPTH, 1024, BRAM depth in bytes.
  - LW, $clog2(DEPTH), byte-address width (localparam).
REQ-002 Ports (name, direction, width, meaning) SHALL be:
  - clka  in  1  single clock, all logic on posedge.
  - rsta  in  1  reset, synchronous and active-high.
  - rN_req  in  1  requester N (N=0,1) access request.
  - rN_gnt  out  1  request accepted this cycle.
  - rN_wen  in  4  byte write strobes; 0 = read.
  - rN_addr  in  LW  byte address.
  - rN_wdata  in  32  write data.
  - rN_rsp  out  1  response valid.
  - rN_rsp_ready  in  1  requester accepts response.
  - rN_rdata  out  32  read data.
  - ena  out  1  BRAM port-A enable.
  - wea  out  4  BRAM port-A byte write enables.
  - addra  out  LW  BRAM port-A address.
  - dina  out  32  BRAM port-A write data.
  - douta  in  32  BRAM port-A read data, valid 1 cycle after ena.

Function
REQ-003 Two requesters SHALL share the single BRAM port A; port B is unused.
REQ-004 FSM states SHALL be IDLE, RESP and HOLD; each holds an owner index (0/1).
REQ-005 Grant SHALL be blocked iff (RESP or HOLD) and owner's rN_rsp_ready=0, or rsta=1; otherwise the winning requester gets a grant.
REQ-006 At most one rN_gnt SHALL be high per cycle.
REQ-007 rN_gnt SHALL be combinational, and rN_req=1 is a precondition for it.
REQ-008 In a grant cycle ena=1, and wea/addra/dina SHALL equal the winner's wen/addr/wdata.
REQ-009 Without a grant, ena=0 and wea=0.
REQ-010 A grant SHALL move the FSM to RESP with owner=winner on the next edge.
REQ-011 In RESP, owner rsp=1 and owner rdata=douta; writes also respond, rdata content don't-care.
REQ-012 In RESP with rsp_ready=1, the FSM SHALL go to RESP if a new grant issues that cycle, else to IDLE.
REQ-013 In RESP with rsp_ready=0, douta SHALL be captured into a 32-bit hold register and the FSM SHALL go to HOLD.
REQ-014 In HOLD, owner rsp=1 and rdata=hold register, stable until accepted.
REQ-015 In HOLD with rsp_ready=1, the FSM SHALL go to RESP (if a new grant issues) or IDLE.
REQ-016 Non-owner rsp SHALL be 0 and its rdata 0; in IDLE both rdata are 0.
REQ-017 Read latency SHALL be grant cycle +1; back-to-back accesses sustain one per cycle while rsp_ready stays high.
REQ-018 A requester SHALL hold req/wen/addr/wdata stable until granted, and the arbiter never drops a pending req.

Reset
REQ-019 While rsta=1, all of the following SHALL hold:
  - rN_gnt=0, ena=0, wea=0.
  - On the next edge: FSM=IDLE, owner=0, hold register=0, rr pointer = "last granted = 1".
REQ-020 rsta asserted in RESP or HOLD SHALL discard the outstanding response, with no rsp pulse after reset.
REQ-021 After rsta deasserts, output values SHALL be rN_rsp=0, rN_rdata=0, addra=0, dina=0.

Configuration
REQ-022 With SCARV_SOC_BRAM_ARB_RR_EN defined, arbitration SHALL be round-robin:
  - On contention, grant the port not granted last.
  - Pointer updates only on a grant.
REQ-023 Without SCARV_SOC_BRAM_ARB_RR_EN, arbitration SHALL be fixed priority with r0 always winning, and no pointer register exists.

Structure
REQ-024 FSM state encodings (IDLE=2'd0, RESP=2'd1, HOLD=2'd2) and the requester count SHALL be defined in the shared scarv_soc package/header.
REQ-025 Winner selection SHALL be one sub-module, scarv_soc_rr_arbiter (2 requests, enable, pointer in, one-hot grant out); it contains the macro-dependent logic.

Verification
REQ-026 Bench SHALL cover these five directed scenarios:
  - Single read: r0 writes 0xDEADBEEF to addr 0x10 with wen=4'hF; r0 reads 0x10 -> r0_gnt same cycle, r0_rsp next cycle, r0_rdata=0xDEADBEEF.
  - Byte strobe: write 0x11223344 to addr 0x20, then 0x000000AA with wen=4'b0001, then read -> 0x112233AA.
  - Contention: r0 and r1 requesting continuously for 6 cycles ->
    - with RR_EN, grants alternate r0,r1,r0,...;
    - without RR_EN, r0 takes all 6 and r1 is starved.
  - Backpressure: r1 reads 0x40 (=0xCAFEF00D) with r1_rsp_ready=0 for 3 cycles ->
    - FSM in HOLD;
    - rdata held at 0xCAFEF00D;
    - no grants to r0 despite r0_req;
    - grant to r0 in the same cycle r1_rsp_ready rises.
  - Reset mid-op: assert rsta in the RESP cycle -> r0_rsp=0 next cycle, ena=0 during reset, first post-reset contention granted to r0.
